handshake_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one single-shot request/response resource between NUM_REQ requesters.
- The resource takes a one-cycle start strobe and later returns an acknowledge.
- The arbiter grants one requester at a time, issues the strobe, waits for the acknowledge with a timeout, then releases and rotates priority.
- It sits between requester front-ends and the shared resource inside a kratos-generated module that carries its own SVA properties.

---
 rtl/handshake_rr_arbiter.sv | 98 +++++++++
 tb/tb_handshake_rr_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter that shares one start/acknowledge resource between
// NUM_REQ requesters, with a bounded wait for the acknowledge.
module handshake_rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int TIMEOUT   = 8,
  parameter int CNT_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic               res_start,
  input  logic               res_ack,
  output logic [NUM_REQ-1:0] done,
  output logic               busy,
  output logic               timeout_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;

  state_t               state;
  logic [IDX_W-1:0]     pointer;
  logic [IDX_W-1:0]     grant_idx;
  logic [IDX_W-1:0]     sel_idx;
  logic [IDX_W-1:0]     cand;
  logic                 sel_valid;
  logic [CNT_WIDTH-1:0] counter;

  // First requester at or above the pointer, wrapping around.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((int'(pointer) + i) % NUM_REQ);
      if (!sel_valid && req[cand]) begin
        sel_valid = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      grant_idx   <= '0;
      pointer     <= '0;
      counter     <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_valid) begin
            grant     <= NUM_REQ'(1) << sel_idx;
            grant_idx <= sel_idx;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          counter <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          // An acknowledge on the last allowed cycle still counts as success.
          if (res_ack) begin
            grant <= '0;
            state <= RELEASE;
          end else if (counter == CNT_LAST) begin
            timeout_err <= 1'b1;
            grant       <= '0;
            state       <= RELEASE;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        RELEASE: begin
          pointer <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign res_start = (state == ISSUE);
  assign busy      = (state != IDLE);
  assign done      = (state == WAIT && res_ack) ? grant : '0;

  a_grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
  a_start_single:  assert property (@(posedge clk) disable iff (rst) res_start |=> !res_start);
  a_done_granted:  assert property (@(posedge clk) disable iff (rst) (done & ~grant) == '0);
  a_start_grant:   assert property (@(posedge clk) disable iff (rst) res_start |-> grant != '0);

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Self-checking bench for handshake_rr_arbiter: vector table, directed corner
// sequences and a randomized run against a transaction-timing reference model.
module tb_handshake_rr_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic         res_ack = 1'b0;
  logic [N-1:0] grant;
  logic         res_start;
  logic [N-1:0] done;
  logic         busy;
  logic         timeout_err;
  logic [10:0]  act;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  handshake_rr_arbiter #(.NUM_REQ(N), .TIMEOUT(TO), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant), .res_start(res_start),
    .res_ack(res_ack), .done(done), .busy(busy), .timeout_err(timeout_err)
  );

  assign act = {grant, res_start, done, busy, timeout_err};

  typedef struct packed {
    logic         r;
    logic [N-1:0] q;
    logic         a;
    logic [N-1:0] g;
    logic         s;
    logic [N-1:0] d;
    logic         b;
    logic         e;
  } vec_t;

  // Reference model: tracks the owner and how many cycles have elapsed since
  // its grant, rather than any state encoding.
  bit m_active, m_release, m_err;
  int m_owner, m_ptr, m_elapsed;

  function automatic logic [10:0] pack_out(logic [N-1:0] g, logic s, logic [N-1:0] d, logic b, logic e);
    return {g, s, d, b, e};
  endfunction

  function automatic logic [10:0] model_out(logic a);
    logic [N-1:0] oh;
    oh = '0;
    oh[m_owner] = 1'b1;
    if (m_active)
      return pack_out(oh, m_elapsed == 1, (m_elapsed >= 2 && a) ? oh : '0, 1'b1, m_err);
    if (m_release)
      return pack_out('0, 1'b0, '0, 1'b1, m_err);
    return pack_out('0, 1'b0, '0, 1'b0, m_err);
  endfunction

  task automatic model_update(input logic r, input logic [N-1:0] q, input logic a);
    int j;
    if (r) begin
      m_active = 0; m_release = 0; m_err = 0; m_ptr = 0; m_owner = 0; m_elapsed = 0;
    end else if (m_release) begin
      m_release = 0;
      m_ptr = (m_owner + 1) % N;
    end else if (m_active) begin
      if (m_elapsed >= 2 && a) begin
        m_active = 0; m_release = 1;
      end else if (m_elapsed == TO + 1) begin
        m_err = 1; m_active = 0; m_release = 1;
      end else begin
        m_elapsed++;
      end
    end else if (q != '0) begin
      for (int k = N - 1; k >= 0; k--) begin
        j = (m_ptr + k) % N;
        if (q[j]) m_owner = j;
      end
      m_active = 1;
      m_elapsed = 1;
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic [N-1:0] q, input logic a);
    @(negedge clk);
    rst = r; req = q; res_ack = a;
    #1;
  endtask

  task automatic check_output(input string name, input logic [10:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got {grant,start,done,busy,err}=%b expected %b", name, act, exp);
    end
  endtask

  task automatic check_value(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic do_reset();
    apply_stimulus(1'b1, '0, 1'b0);
    apply_stimulus(1'b1, '0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vt [13];
    logic [N-1:0] rr_exp [5];
    int k, last_c;

    // Reset, first grant 0001, then a 0100 transaction acked on its third WAIT cycle.
    vt[0]  = '{1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 4'hF, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 4'hF, 1'b1, 4'h1, 1'b1, 4'h0, 1'b1, 1'b0};
    vt[4]  = '{1'b0, 4'h0, 1'b1, 4'h1, 1'b0, 4'h1, 1'b1, 1'b0};
    vt[5]  = '{1'b0, 4'h4, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0};
    vt[6]  = '{1'b0, 4'h4, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 4'h0, 1'b0, 4'h4, 1'b1, 4'h0, 1'b1, 1'b0};
    vt[8]  = '{1'b0, 4'h0, 1'b0, 4'h4, 1'b0, 4'h0, 1'b1, 1'b0};
    vt[9]  = '{1'b0, 4'h0, 1'b0, 4'h4, 1'b0, 4'h0, 1'b1, 1'b0};
    vt[10] = '{1'b0, 4'h0, 1'b1, 4'h4, 1'b0, 4'h4, 1'b1, 1'b0};
    vt[11] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0};
    vt[12] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};

    for (int i = 0; i < 13; i++) begin
      apply_stimulus(vt[i].r, vt[i].q, vt[i].a);
      check_output($sformatf("table[%0d]", i), pack_out(vt[i].g, vt[i].s, vt[i].d, vt[i].b, vt[i].e));
    end

    // Round robin with every requester active and ack held high.
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
    do_reset();
    k = 0;
    last_c = 0;
    for (int c = 0; c < 40 && k < 5; c++) begin
      apply_stimulus(1'b0, 4'hF, 1'b1);
      if (res_start) begin
        check_value($sformatf("rr_grant[%0d]", k), int'(grant), int'(rr_exp[k]));
        check_value("rr_issue_done", int'(done), 0);
        if (k > 0) check_value("rr_spacing", c - last_c, 4);
        last_c = c;
        k++;
      end
    end
    check_value("rr_grant_count", k, 5);

    // No acknowledge: eight WAIT cycles, sticky error, arbitration continues.
    do_reset();
    apply_stimulus(1'b0, 4'b0010, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      apply_stimulus(1'b0, 4'b0000, 1'b0);
      check_output($sformatf("timeout_c%0d", c),
                   pack_out((c <= 9) ? 4'b0010 : 4'b0000, c == 1, 4'b0000, c <= 10, c >= 10));
    end
    apply_stimulus(1'b0, 4'b0001, 1'b0);
    apply_stimulus(1'b0, 4'b0000, 1'b0);
    check_output("after_timeout_grant", pack_out(4'b0001, 1'b1, 4'b0000, 1'b1, 1'b1));

    // Ack on the last allowed WAIT cycle wins over the timeout.
    do_reset();
    apply_stimulus(1'b0, 4'b0010, 1'b0);
    for (int c = 1; c <= 8; c++) apply_stimulus(1'b0, 4'b0000, 1'b0);
    apply_stimulus(1'b0, 4'b0000, 1'b1);
    check_output("late_ack_done", pack_out(4'b0010, 1'b0, 4'b0010, 1'b1, 1'b0));
    apply_stimulus(1'b0, 4'b0000, 1'b0);
    check_output("late_ack_release", pack_out(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0));

    // Reset in the middle of WAIT drops the transaction and the pointer.
    do_reset();
    apply_stimulus(1'b0, 4'b1000, 1'b0);
    apply_stimulus(1'b0, 4'b0000, 1'b0);
    check_output("midrst_grant", pack_out(4'b1000, 1'b1, 4'b0000, 1'b1, 1'b0));
    apply_stimulus(1'b0, 4'b0000, 1'b0);
    apply_stimulus(1'b1, 4'b0000, 1'b0);
    apply_stimulus(1'b0, 4'b0000, 1'b1);
    check_output("midrst_cleared", pack_out(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0));
    apply_stimulus(1'b0, 4'b1111, 1'b0);
    apply_stimulus(1'b0, 4'b0000, 1'b0);
    check_output("midrst_pointer", pack_out(4'b0001, 1'b1, 4'b0000, 1'b1, 1'b0));

    // Randomized run against the reference model.
    do_reset();
    model_update(1'b1, '0, 1'b0);
    for (int c = 0; c < 800; c++) begin
      logic r, a;
      logic [N-1:0] q;
      r = ($urandom_range(0, 199) == 0);
      q = ($urandom_range(0, 1) == 0) ? N'($urandom) : '0;
      a = ($urandom_range(0, 5) == 0);
      apply_stimulus(r, q, a);
      check_output($sformatf("random_c%0d", c), model_out(a));
      model_update(r, q, a);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
